// File: rtl/lfsr_generator.sv
// -----------------------------------------------------------------------------
// lfsr_generator
//
// Transmit-side PRBS word source. Emits the 8-bit Galois LFSR sequence
// x^8+x^4+x^3+x^2+1 with zero-state insertion, so the period is 256 words and
// includes 0x00. Words leave through a valid/ready handshake. The block also
// supports continuous or burst/gap pacing, seed reload/flush, single-word error
// injection and a one-cycle marker when the sequence returns to its seed.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | not running, o_valid=0, waits for i_enable
// RUN   | o_valid=1, one word offered per cycle until accepted
// GAP   | inter-burst idle, o_valid=0 for GAP_LEN cycles
//
// Ports
//   clk           clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_enable      run request
//   i_load_seed   synchronous seed load and flush (highest priority)
//   i_seed        seed value, sampled with i_load_seed
//   i_inject_err  pulse: corrupt the next transferred word with ERR_MASK
//   i_ready       downstream accept
//   o_lfsr        data word
//   o_valid       o_lfsr valid
//   o_wrap        one-cycle pulse after the transfer that returns to the seed
//   o_word_cnt    transferred-word count, modulo 2^16
// -----------------------------------------------------------------------------
module lfsr_generator #(
  parameter logic [7:0] DEFAULT_SEED = 8'hFF,
  parameter int         BURST_LEN    = 0,
  parameter int         GAP_LEN      = 4,
  parameter logic [7:0] ERR_MASK     = 8'h01
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_load_seed,
  input  logic [7:0]  i_seed,
  input  logic        i_inject_err,
  input  logic        i_ready,
  output logic [7:0]  o_lfsr,
  output logic        o_valid,
  output logic        o_wrap,
  output logic [15:0] o_word_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [15:0] BURST_LAST = (BURST_LEN > 0) ? 16'(BURST_LEN - 1) : 16'd0;
  localparam logic [15:0] GAP_LAST   = (GAP_LEN > 0)   ? 16'(GAP_LEN - 1)   : 16'd0;

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_next, start_seed_q;
  logic        err_pending_q;
  logic [15:0] burst_cnt_q, gap_cnt_q, word_cnt_q;
  logic        wrap_q;
  logic        xfer, burst_end;

  // One Galois step; the (q[6:0]==0) term splices 0x00 into the cycle
  // between 0x80 and 0x1D.
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    logic       fb;
    logic [7:0] n;
    fb   = q[7] ^ (q[6:0] == 7'd0);
    n[0] = fb;
    n[1] = q[0];
    n[2] = q[1] ^ fb;
    n[3] = q[2] ^ fb;
    n[4] = q[3] ^ fb;
    n[5] = q[4];
    n[6] = q[5];
    n[7] = q[6];
    return n;
  endfunction

  assign lfsr_next = lfsr_step(lfsr_q);
  assign xfer      = o_valid & i_ready;
  assign burst_end = (BURST_LEN > 0) && (burst_cnt_q == BURST_LAST);

  // State register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (i_load_seed) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_enable) state_d = S_RUN;
        S_RUN: begin
          // valid is held until accepted, even if i_enable falls
          if (xfer) begin
            if (burst_end)      state_d = S_GAP;
            else if (!i_enable) state_d = S_IDLE;
          end
        end
        S_GAP: if (gap_cnt_q == 16'd0) state_d = i_enable ? S_RUN : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs, decoded from registered state only
  always_comb begin
    o_valid = 1'b0;
    unique case (state_q)
      S_RUN:   o_valid = 1'b1;
      default: o_valid = 1'b0;
    endcase
  end

  // Datapath and pacing counters
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q        <= DEFAULT_SEED;
      start_seed_q  <= DEFAULT_SEED;
      err_pending_q <= 1'b0;
      burst_cnt_q   <= 16'd0;
      gap_cnt_q     <= 16'd0;
      word_cnt_q    <= 16'd0;
      wrap_q        <= 1'b0;
    end else if (i_load_seed) begin
      lfsr_q        <= i_seed;
      start_seed_q  <= i_seed;
      err_pending_q <= 1'b0;
      burst_cnt_q   <= 16'd0;
      gap_cnt_q     <= 16'd0;
      word_cnt_q    <= 16'd0;
      wrap_q        <= 1'b0;
    end else begin
      wrap_q <= xfer && (lfsr_next == start_seed_q);

      if (xfer) begin
        lfsr_q     <= lfsr_next;
        word_cnt_q <= word_cnt_q + 16'd1;
        // the word going out now carries the old flag; a coincident pulse
        // arms the next word, a pulse while already armed is absorbed
        err_pending_q <= i_inject_err & ~err_pending_q;
      end else if (i_inject_err) begin
        err_pending_q <= 1'b1;
      end

      if (xfer) begin
        if (burst_end || BURST_LEN == 0) burst_cnt_q <= 16'd0;
        else                             burst_cnt_q <= burst_cnt_q + 16'd1;
      end

      if (xfer && burst_end)
        gap_cnt_q <= GAP_LAST;
      else if (state_q == S_GAP && gap_cnt_q != 16'd0)
        gap_cnt_q <= gap_cnt_q - 16'd1;
    end
  end

  assign o_lfsr     = lfsr_q ^ (err_pending_q ? ERR_MASK : 8'h00);
  assign o_wrap     = wrap_q;
  assign o_word_cnt = word_cnt_q;

endmodule

// File: tb/tb_lfsr_generator.sv
// Bench for lfsr_generator: dut0 runs continuous mode, dut1 runs
// BURST_LEN=3 / GAP_LEN=2. Stimulus pushes expected words into queues; monitors
// pop and compare whenever a word is accepted.
module tb_lfsr_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en0 = 1'b0, en1 = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic        inject = 1'b0;
  logic        ready = 1'b0;

  logic [7:0]  lfsr0, lfsr1;
  logic        valid0, valid1, wrap0, wrap1;
  logic [15:0] cnt0, cnt1;

  int checks = 0;
  int failures = 0;
  int tb_cnt = 0;
  int wraps = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];

  always #5 clk = ~clk;

  lfsr_generator #(.DEFAULT_SEED(8'hFF), .BURST_LEN(0), .GAP_LEN(4), .ERR_MASK(8'h01)) dut0 (
    .clk(clk), .i_rst(rst), .i_enable(en0), .i_load_seed(load), .i_seed(seed),
    .i_inject_err(inject), .i_ready(ready), .o_lfsr(lfsr0), .o_valid(valid0),
    .o_wrap(wrap0), .o_word_cnt(cnt0));

  lfsr_generator #(.DEFAULT_SEED(8'hFF), .BURST_LEN(3), .GAP_LEN(2), .ERR_MASK(8'h01)) dut1 (
    .clk(clk), .i_rst(rst), .i_enable(en1), .i_load_seed(load), .i_seed(seed),
    .i_inject_err(1'b0), .i_ready(ready), .o_lfsr(lfsr1), .o_valid(valid1),
    .o_wrap(wrap1), .o_word_cnt(cnt1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference step written as a plain left-shift Galois LFSR (poly 0x1D)
  // with the zero state spliced in explicitly.
  function automatic logic [7:0] model_next(input logic [7:0] q);
    if (q == 8'h80) return 8'h00;
    if (q == 8'h00) return 8'h1D;
    return {q[6:0], 1'b0} ^ (q[7] ? 8'h1D : 8'h00);
  endfunction

  // dut0 scoreboard monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst || load) begin
        tb_cnt = 0;
      end else begin
        if (wrap0) begin
          wraps++;
          chk("wrap_cnt", 32'(cnt0), 32'(tb_cnt));
          chk("wrap_at_256", 32'(tb_cnt % 256), 32'd0);
        end
        if (valid0 && ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word0", 32'(lfsr0), 32'h1FF);
          end else begin
            e = exp_q.pop_front();
            chk("data0", 32'(lfsr0), 32'(e));
          end
          chk("word_cnt0", 32'(cnt0), 32'(tb_cnt % 65536));
          tb_cnt++;
        end
      end
    end
  end

  // dut1 scoreboard monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && !load && valid1 && ready) begin
        if (exp1_q.size() == 0) begin
          chk("unexpected_word1", 32'(lfsr1), 32'h1FF);
        end else begin
          e = exp1_q.pop_front();
          chk("data1", 32'(lfsr1), 32'(e));
        end
      end
    end
  end

  task automatic load_seed(input logic [7:0] s);
    @(posedge clk); #1;
    load = 1'b1; seed = s;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic push_list(input logic [7:0] w[$]);
    foreach (w[i]) exp_q.push_back(w[i]);
  endtask

  task automatic wait_words(input int k);
    int seen = 0;
    int guard = 0;
    while (seen < k && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (valid0 && ready) seen++;
    end
    chk("wait_words", 32'(seen), 32'(k));
  endtask

  // Deliver exactly n words from IDLE, dropping enable so the nth is last.
  task automatic run_n(input int n);
    int seen = 0;
    int guard = 0;
    en0 = 1'b1; ready = 1'b1;
    while (seen < n - 1 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (valid0 && ready) seen++;
    end
    chk("run_seen", 32'(seen), 32'(n - 1));
    @(posedge clk); #1;
    en0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int pat[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    logic [7:0] m;
    int w0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_wrap", 32'(wrap0), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_lfsr", 32'(lfsr0), 32'hFF);
    rst = 1'b0;

    // default seed FF: first two words
    push_list('{8'hFF, 8'hE3});
    run_n(2);

    // seed 01: ten-word sequence through the zero state
    load_seed(8'h01);
    push_list('{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h1D});
    run_n(10);
    chk("seq_cnt", 32'(cnt0), 32'd10);

    // backpressure, with enable dropped during the stall
    load_seed(8'h01);
    push_list('{8'h01, 8'h02, 8'h04, 8'h08});
    en0 = 1'b1; ready = 1'b1;
    wait_words(3);
    @(posedge clk); #1;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(valid0), 32'd1);
      chk("stall_data", 32'(lfsr0), 32'h08);
      if (i == 2) en0 = 1'b0;
    end
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_stall_valid", 32'(valid0), 32'd0);
    chk("after_stall_cnt", 32'(cnt0), 32'd4);
    push_list('{8'h10, 8'h20});
    run_n(2);
    chk("resume_cnt", 32'(cnt0), 32'd6);

    // error injection: pulse coincides with transfer 2, so word 3 is hit
    load_seed(8'h01);
    push_list('{8'h01, 8'h02, 8'h05, 8'h08});
    en0 = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(posedge clk); #1;
    en0 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_cnt", 32'(cnt0), 32'd4);
    chk("err_idle", 32'(valid0), 32'd0);
    push_list('{8'h10});
    run_n(1);

    // burst pacing on dut1
    load_seed(8'h01);
    exp1_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    en1 = 1'b1; ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("burst_valid_%0d", i), 32'(valid1), 32'(pat[i]));
    end
    en1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("burst_queue_drained", 32'(exp1_q.size()), 32'd0);
    chk("burst_cnt", 32'(cnt1), 32'd6);
    ready = 1'b0;

    // flush while stalled
    load_seed(8'h01);
    push_list('{8'h01});
    en0 = 1'b1; ready = 1'b1;
    wait_words(1);
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    chk("pre_flush_valid", 32'(valid0), 32'd1);
    chk("pre_flush_cnt", 32'(cnt0), 32'd1);
    chk("pre_flush_data", 32'(lfsr0), 32'h02);
    @(posedge clk); #1;
    load = 1'b1; seed = 8'h55; en0 = 1'b0;
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(valid0), 32'd0);
    chk("flush_cnt", 32'(cnt0), 32'd0);
    chk("flush_data", 32'(lfsr0), 32'h55);

    // wrap markers over two full periods from seed FF
    load_seed(8'hFF);
    m = 8'hFF;
    for (int i = 0; i < 520; i++) begin
      exp_q.push_back(m);
      m = model_next(m);
    end
    w0 = wraps;
    run_n(520);
    chk("wrap_pulses", 32'(wraps - w0), 32'd2);
    chk("wrap_total_cnt", 32'(cnt0), 32'd520);

    // async reset mid-stream with an armed error
    load_seed(8'h01);
    push_list('{8'h01, 8'h02});
    en0 = 1'b1; ready = 1'b1;
    wait_words(2);
    @(posedge clk); #1;
    ready = 1'b0; inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(negedge clk);
    chk("armed_data", 32'(lfsr0), 32'h05);
    en0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid0), 32'd0);
    chk("arst_wrap", 32'(wrap0), 32'd0);
    chk("arst_cnt", 32'(cnt0), 32'd0);
    chk("arst_lfsr", 32'(lfsr0), 32'hFF);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
